// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int WORD = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD-1:0] alignWord(input logic [WORD-1:0] pc);
        return pc & ~WORD'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO holding {instr, pc} entries; flush dominates push.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  T                         i_data,
    output T                         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_rdPtr;
    logic [AW-1:0]  r_wrPtr;
    logic [CW-1:0]  r_count;
    logic           w_doPush;
    logic           w_doPop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            assert (!(i_push && o_full && !w_doPop));
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed saturating counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [WORD-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [WORD-1:0] instr,
    output logic [WORD-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD-1:0] r_fetchPc;
    logic [WORD-1:0] r_rspPc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_discard;
    logic            r_postReset;

    logic            w_issue;
    logic            w_keep;
    logic            w_pop;
    logic [OW-1:0]   w_outstNext;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_pushEntry;
    fetch_entry_t    w_head;

    // Requests are held off one extra cycle after reset so the memory sees a quiet bus.
    assign imem_req = !reset && !r_postReset && !redirect
                   && (32'(r_outst) < MAX_OUTST)
                   && ((32'(w_count) + 32'(r_outst)) < DEPTH);
    assign imem_addr   = r_fetchPc;
    assign w_issue     = imem_req && imem_gnt;
    assign w_keep      = imem_rvalid && !redirect && (r_discard == '0);
    assign w_outstNext = r_outst + OW'(w_issue) - OW'(imem_rvalid);
    assign w_pushEntry = '{instr: imem_rdata, pc: r_rspPc};

    assign instr_valid = !reset && !w_empty && !redirect;
    assign w_pop       = instr_valid && instr_ready;
    assign instr       = reset ? '0 : w_head.instr;
    assign instr_pc    = reset ? '0 : w_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_pushEntry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // On redirect every request still in flight after this edge becomes a discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetchPc   <= RESET_PC;
            r_rspPc     <= RESET_PC;
            r_outst     <= '0;
            r_discard   <= '0;
            r_postReset <= 1'b1;
        end else begin
            assert (!imem_rvalid || (r_outst != '0));
            assert (32'(w_outstNext) <= MAX_OUTST);
            assert (32'(r_discard) <= MAX_OUTST);
            assert (!(w_keep && w_full && !w_pop));
            r_postReset <= 1'b0;
            r_outst     <= w_outstNext;
            if (redirect) begin
                r_fetchPc <= alignWord(redirect_pc);
                r_rspPc   <= alignWord(redirect_pc);
                r_discard <= w_outstNext;
            end else begin
                if (w_issue) begin
                    r_fetchPc <= r_fetchPc + 32'd4;
                end
                if (w_keep) begin
                    r_rspPc <= r_rspPc + 32'd4;
                end
                if (imem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - OW'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetched;
    logic [31:0] r_perfFlushed;
    logic [CW:0] w_flushInc;
    logic [32:0] w_flushSum;

    assign w_flushInc   = (redirect ? {1'b0, w_count} : '0) + (CW + 1)'(imem_rvalid && !w_keep);
    assign w_flushSum   = {1'b0, r_perfFlushed} + 33'(w_flushInc);
    assign perf_fetched = r_perfFetched;
    assign perf_flushed = r_perfFlushed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perfFetched <= '0;
            r_perfFlushed <= '0;
        end else begin
            if (w_keep && (r_perfFetched != '1)) begin
                r_perfFetched <= r_perfFetched + 32'd1;
            end
            r_perfFlushed <= w_flushSum[32] ? '1 : w_flushSum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a 1-cycle in-order instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    pend_t        pending[$];
    fetch_entry_t sb[$];
    logic [31:0]  popLog[$];
    logic [31:0]  obsLog[$];
    logic [31:0]  expIssue = 32'h0;
    bit           postReset = 1'b0;
    bit           obsValid;
    bit           obsReq;
    int           perfFetchedExp = 0;
    int           perfFlushedExp = 0;
    int           gntMode = 1;
    int           memMode = 1;
    int           readyMode = 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit pickMode(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check settled outputs, then advance the model.
    task automatic applyStimulus(input bit doRedirect, input logic [31:0] target, input bit doReset);
        bit    expReq;
        bit    expValid;
        pend_t e;
        reset       = doReset;
        redirect    = doRedirect;
        redirect_pc = target;
        imem_gnt    = pickMode(gntMode);
        instr_ready = pickMode(readyMode);
        if (!doReset && pickMode(memMode) && pending.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(pending[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        expReq   = !doReset && !postReset && !doRedirect && pending.size() < 2
                && (sb.size() + pending.size()) < 4;
        expValid = !doReset && !doRedirect && sb.size() > 0;
        obsValid = instr_valid;
        obsReq   = imem_req;
        checkOutput("req", 32'(imem_req), 32'(expReq));
        if (expReq) checkOutput("addr", imem_addr, expIssue);
        checkOutput("valid", 32'(instr_valid), 32'(expValid));
        if (expValid) begin
            checkOutput("pc", instr_pc, sb[0].pc);
            checkOutput("instr", instr, sb[0].instr);
        end
        if (doReset || postReset) begin
            checkOutput("rstInstr", instr, 32'h0);
            checkOutput("rstPc", instr_pc, 32'h0);
        end
        if (doReset) begin
            pending.delete();
            sb.delete();
            expIssue       = 32'h0;
            postReset      = 1'b1;
            perfFetchedExp = 0;
            perfFlushedExp = 0;
        end else begin
            postReset = 1'b0;
            if (expValid && instr_ready) begin
                popLog.push_back(instr_pc);
                void'(sb.pop_front());
            end
            if (imem_rvalid) begin
                e = pending.pop_front();
                if (!e.stale && !doRedirect) begin
                    sb.push_back('{instr: memWord(e.addr), pc: e.addr});
                    perfFetchedExp++;
                end else begin
                    perfFlushedExp++;
                end
            end
            if (expReq && imem_gnt) begin
                obsLog.push_back(imem_addr);
                pending.push_back('{addr: expIssue, stale: 1'b0});
                expIssue += 32'd4;
            end
            if (doRedirect) begin
                perfFlushedExp += sb.size();
                sb.delete();
                foreach (pending[i]) pending[i].stale = 1'b1;
                expIssue = target & ~32'h3;
            end
        end
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        popLog.delete();
        obsLog.delete();
    endtask

    task automatic checkPerf(input string tag);
`ifdef FETCH_PERF_EN
        checkOutput({tag, "Fetched"}, perf_fetched, 32'(perfFetchedExp));
        checkOutput({tag, "Flushed"}, perf_flushed, 32'(perfFlushedExp));
`else
        checks += 0;
`endif
    endtask

    initial begin
        @(negedge clk);
        doReset();

        // Streaming fetch, no bubbles once the pipe fills.
        gntMode = 1; memMode = 1; readyMode = 1;
        runCycles(13);
        checkOutput("t1Pops", popLog.size(), 10);
        if (popLog.size() > 2) checkOutput("t1Pc2", popLog[2], 32'h8);

        // Back-pressure fills exactly DEPTH entries, then order continues.
        doReset();
        readyMode = 0;
        runCycles(12);
        checkOutput("t2Issues", obsLog.size(), 4);
        if (obsLog.size() > 3) checkOutput("t2Addr3", obsLog[3], 32'hC);
        readyMode = 1;
        obsLog.delete();
        runCycles(8);
        if (popLog.size() > 4) checkOutput("t2Pc4", popLog[4], 32'h10);
        else checkOutput("t2Pops", popLog.size(), 5);
        if (obsLog.size() > 0) checkOutput("t2Reissue", obsLog[0], 32'h10);

        // Redirect with two requests in flight; both responses dropped.
        doReset();
`ifdef FETCH_PERF_EN
        checkOutput("t3PerfRstA", perf_fetched, 32'h0);
        checkOutput("t3PerfRstB", perf_flushed, 32'h0);
`endif
        gntMode = 1; memMode = 0; readyMode = 1;
        runCycles(4);
        gntMode = 0; memMode = 1;
        runCycles(3);
        gntMode = 1; memMode = 0;
        obsLog.delete();
        runCycles(3);
        checkOutput("t3Outst", obsLog.size(), 2);
        if (obsLog.size() > 1) begin
            checkOutput("t3AddrA", obsLog[0], 32'h8);
            checkOutput("t3AddrB", obsLog[1], 32'hC);
        end
        popLog.delete();
        obsLog.delete();
        applyStimulus(1'b1, 32'h103, 1'b0);
        memMode = 1;
        runCycles(6);
        if (popLog.size() > 0) checkOutput("t3Pc", popLog[0], 32'h100);
        else checkOutput("t3Pops", popLog.size(), 1);
        if (obsLog.size() > 0) checkOutput("t3Addr", obsLog[0], 32'h100);
`ifdef FETCH_PERF_EN
        checkOutput("t3Flushed", perf_flushed, 32'h2);
`endif
        checkPerf("t3Perf");

        // Redirect coincident with rvalid: the word never enters the FIFO.
        doReset();
        gntMode = 1; memMode = 1; readyMode = 0;
        runCycles(3);
        memMode = 0;
        runCycles(2);
        memMode = 1;
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("t4Valid", 32'(obsValid), 32'h0);
        readyMode = 1;
        popLog.delete();
        runCycles(6);
        if (popLog.size() > 0) checkOutput("t4Pc", popLog[0], 32'h200);
        else checkOutput("t4Pops", popLog.size(), 1);
        checkPerf("t4Perf");

        // Address wrap at the top of the 32-bit space.
        obsLog.delete();
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
        runCycles(6);
        if (obsLog.size() > 2) begin
            checkOutput("t5A0", obsLog[0], 32'hFFFF_FFF8);
            checkOutput("t5A1", obsLog[1], 32'hFFFF_FFFC);
            checkOutput("t5A2", obsLog[2], 32'h0000_0000);
        end else begin
            checkOutput("t5Issues", obsLog.size(), 3);
        end

        // Random traffic with occasional redirects.
        gntMode = 2; memMode = 2; readyMode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) applyStimulus(1'b1, $urandom, 1'b0);
            else applyStimulus(1'b0, 32'h0, 1'b0);
        end
        checkPerf("rndPerf");

        // Reset while the FIFO is full.
        gntMode = 1; memMode = 1; readyMode = 0;
        runCycles(10);
        checkOutput("t6Full", 32'(obsValid), 32'h1);
        doReset();
        runCycles(1);
        checkOutput("t6Req", 32'(obsReq), 32'h0);
        checkOutput("t6Valid", 32'(obsValid), 32'h0);
        runCycles(1);
        if (obsLog.size() > 0) checkOutput("t6Addr", obsLog[0], 32'h0);
        else checkOutput("t6Issues", obsLog.size(), 1);
        checkPerf("t6Perf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
